// File: rtl/sprite_merge_if.sv
// Pixel bundle between the bg/sprite pipelines, sprite_merge and the VGA side.
// Signal names match the compositor's documented port list.
interface sprite_merge_if;
  logic         readVgaSelector;
  logic [7:0]   R_bg, G_bg, B_bg;
  logic [9:0]   posX_bg, posY_bg;
  logic [7:0]   R_sp, G_sp, B_sp;
  logic [9:0]   posX_sp, posY_sp;
  logic [127:0] R_outRegA, G_outRegA, B_outRegA;
  logic [127:0] R_outRegB, G_outRegB, B_outRegB;
  logic [3:0]   collision;

  modport master (
    output readVgaSelector,
    output R_bg, G_bg, B_bg, posX_bg, posY_bg,
    output R_sp, G_sp, B_sp, posX_sp, posY_sp,
    input  R_outRegA, G_outRegA, B_outRegA,
    input  R_outRegB, G_outRegB, B_outRegB,
    input  collision
  );

  modport slave (
    input  readVgaSelector,
    input  R_bg, G_bg, B_bg, posX_bg, posY_bg,
    input  R_sp, G_sp, B_sp, posX_sp, posY_sp,
    output R_outRegA, G_outRegA, B_outRegA,
    output R_outRegB, G_outRegB, B_outRegB,
    output collision
  );
endinterface

// File: rtl/sprite_merge.sv
// Sprite/background compositor into A/B ping-pong 16-pixel line buffers.
// Optional: define TRANSPARENCY_EN to treat TRANSP_KEY sprite pixels as clear.
module sprite_merge #(
  parameter int unsigned SPRITE_W   = 16,
  parameter int unsigned SPRITE_H   = 16,
  parameter int unsigned X_MIN      = 1,
  parameter int unsigned X_MAX      = 990,
  parameter int unsigned Y_MIN      = 1,
  parameter int unsigned Y_MAX      = 990,
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
  input logic            clk,
  input logic            reset,
  sprite_merge_if.slave  io
);

  localparam logic [10:0] SW   = 11'(SPRITE_W);
  localparam logic [10:0] SH   = 11'(SPRITE_H);
  localparam logic [9:0]  XMIN = 10'(X_MIN);
  localparam logic [9:0]  XMAX = 10'(X_MAX);
  localparam logic [9:0]  YMIN = 10'(Y_MIN);
  localparam logic [9:0]  YMAX = 10'(Y_MAX);

  logic [127:0] r_a, g_a, b_a;
  logic [127:0] r_b, g_b, b_b;
  logic [3:0]   idx;
  logic         prev_sel;
  logic [3:0]   coll_q;

  logic [10:0] x_end, y_end;
  logic        in_x, in_y, opaque, use_sp;
  logic [7:0]  r_m, g_m, b_m;
  logic        swap;
  logic [3:0]  slot;

  // 11-bit box ends so a sprite near 1023 never wraps back to column 0
  assign x_end = {1'b0, io.posX_sp} + SW;
  assign y_end = {1'b0, io.posY_sp} + SH;
  assign in_x  = (io.posX_bg >= io.posX_sp)
               && ({1'b0, io.posX_bg} < x_end);
  assign in_y  = (io.posY_bg >= io.posY_sp)
               && ({1'b0, io.posY_bg} < y_end);

`ifdef TRANSPARENCY_EN
  assign opaque = {io.R_sp, io.G_sp, io.B_sp} != TRANSP_KEY;
`else
  logic unused_key;
  assign unused_key = ^TRANSP_KEY;
  assign opaque     = 1'b1;
`endif

  assign use_sp = in_x & in_y & opaque;
  assign r_m    = use_sp ? io.R_sp : io.R_bg;
  assign g_m    = use_sp ? io.G_sp : io.G_bg;
  assign b_m    = use_sp ? io.B_sp : io.B_bg;

  // a selector change restarts the new write bank at slot 0
  assign swap = io.readVgaSelector != prev_sel;
  assign slot = swap ? 4'd0 : idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      g_a      <= '0;
      b_a      <= '0;
      r_b      <= '0;
      g_b      <= '0;
      b_b      <= '0;
      idx      <= 4'd0;
      prev_sel <= 1'b1;
      coll_q   <= 4'd0;
    end else begin
      prev_sel <= io.readVgaSelector;
      idx      <= slot + 4'd1;
      if (io.readVgaSelector) begin
        r_a[slot*8 +: 8] <= r_m;
        g_a[slot*8 +: 8] <= g_m;
        b_a[slot*8 +: 8] <= b_m;
      end else begin
        r_b[slot*8 +: 8] <= r_m;
        g_b[slot*8 +: 8] <= g_m;
        b_b[slot*8 +: 8] <= b_m;
      end
      coll_q <= {io.posY_sp >= YMAX,
                 io.posY_sp <= YMIN,
                 io.posX_sp >= XMAX,
                 io.posX_sp <= XMIN};
    end
  end

  assign io.R_outRegA = r_a;
  assign io.G_outRegA = g_a;
  assign io.B_outRegA = b_a;
  assign io.R_outRegB = r_b;
  assign io.G_outRegB = g_b;
  assign io.B_outRegB = b_b;
  assign io.collision = coll_q;

endmodule

// File: tb/tb_sprite_merge.sv
// Scoreboard bench for sprite_merge: directed pixels, queued expectations,
// monitor compares the written slot and collision after each clock.
module tb_sprite_merge;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sprite_merge_if bus();

  sprite_merge dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bank;
    logic [3:0] slot;
    logic [23:0] rgb;
    logic [3:0] col;
  } exp_t;

  exp_t q[$];

  logic [127:0] m_ra, m_ga, m_ba, m_rb, m_gb, m_bb;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_ra = '0; m_ga = '0; m_ba = '0;
    m_rb = '0; m_gb = '0; m_bb = '0;
  endtask

  // drive one pixel at negedge; expected bank/slot/colour/collision by hand
  task automatic pix(input logic sel,
                     input logic [19:0] bgxy, input logic [23:0] bgc,
                     input logic [19:0] spxy, input logic [23:0] spc,
                     input logic bank, input logic [3:0] slot,
                     input logic [23:0] ec, input logic [3:0] col);
    exp_t e;
    @(negedge clk);
    bus.readVgaSelector = sel;
    {bus.posX_bg, bus.posY_bg} = bgxy;
    {bus.R_bg, bus.G_bg, bus.B_bg} = bgc;
    {bus.posX_sp, bus.posY_sp} = spxy;
    {bus.R_sp, bus.G_sp, bus.B_sp} = spc;
    e.bank = bank;
    e.slot = slot;
    e.rgb  = ec;
    e.col  = col;
    q.push_back(e);
    if (bank) begin
      m_ra[slot*8 +: 8] = ec[23:16];
      m_ga[slot*8 +: 8] = ec[15:8];
      m_ba[slot*8 +: 8] = ec[7:0];
    end else begin
      m_rb[slot*8 +: 8] = ec[23:16];
      m_gb[slot*8 +: 8] = ec[15:8];
      m_bb[slot*8 +: 8] = ec[7:0];
    end
  endtask

  task automatic chk_bufs(input string tag);
    chk({tag, " RA"}, bus.R_outRegA, m_ra);
    chk({tag, " GA"}, bus.G_outRegA, m_ga);
    chk({tag, " BA"}, bus.B_outRegA, m_ba);
    chk({tag, " RB"}, bus.R_outRegB, m_rb);
    chk({tag, " GB"}, bus.G_outRegB, m_gb);
    chk({tag, " BB"}, bus.B_outRegB, m_bb);
  endtask

  // monitor: output is presented every clock, one expectation per edge
  initial begin
    exp_t e;
    logic [127:0] ar, ag, ab;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ar = e.bank ? bus.R_outRegA : bus.R_outRegB;
        ag = e.bank ? bus.G_outRegA : bus.G_outRegB;
        ab = e.bank ? bus.B_outRegA : bus.B_outRegB;
        chk("slot R", {120'd0, ar[e.slot*8 +: 8]}, {120'd0, e.rgb[23:16]});
        chk("slot G", {120'd0, ag[e.slot*8 +: 8]}, {120'd0, e.rgb[15:8]});
        chk("slot B", {120'd0, ab[e.slot*8 +: 8]}, {120'd0, e.rgb[7:0]});
        chk("collision", {124'd0, bus.collision}, {124'd0, e.col});
      end
    end
  end

  localparam logic [19:0] SP_FAR = {10'd600, 10'd600};

  initial begin
    logic [23:0] bgc;
    bus.readVgaSelector = 1'b1;
    bus.R_bg = 8'h0; bus.G_bg = 8'h0; bus.B_bg = 8'h0;
    bus.posX_bg = 10'd0; bus.posY_bg = 10'd0;
    bus.R_sp = 8'h0; bus.G_sp = 8'h0; bus.B_sp = 8'h0;
    bus.posX_sp = 10'd500; bus.posY_sp = 10'd500;
    model_clear();

    repeat (3) @(posedge clk);
    #2;
    chk_bufs("reset");
    chk("reset collision", {124'd0, bus.collision}, 128'd0);
    #1 reset = 1'b1;

    // boundary flags and cover basics
    pix(1, {10'd500, 10'd500}, 24'h205040, {10'd1, 10'd1}, 24'h171717,
        1, 4'd0, 24'h205040, 4'b0101);
    @(posedge clk); #2;
    chk("B idle R", bus.R_outRegB, 128'd0);
    chk("B idle G", bus.G_outRegB, 128'd0);
    pix(1, {10'd500, 10'd500}, 24'h010203, {10'd990, 10'd1}, 24'h171717,
        1, 4'd1, 24'h010203, 4'b0110);
    pix(1, {10'd500, 10'd500}, 24'h040506, {10'd1, 10'd990}, 24'h171717,
        1, 4'd2, 24'h040506, 4'b1001);
    pix(1, {10'd5, 10'd5}, 24'h999999, {10'd1, 10'd1}, 24'h171717,
        1, 4'd3, 24'h171717, 4'b0101);
    @(posedge clk); #2;
    chk_bufs("first4");

    // restart from reset, then 16-pixel fill crossing the sprite left edge
    #1 reset = 1'b0;
    #1 model_clear();
    chk_bufs("reset2");
    @(posedge clk); #3 reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bgc = {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)};
      pix(1, {10'(590 + i), 10'd600}, bgc, SP_FAR, 24'hAABBCC,
          1, 4'(i), (i >= 10) ? 24'hAABBCC : bgc, 4'b0000);
    end
    @(posedge clk); #2;
    chk_bufs("fill16");
    // wrap overwrites slot 0; box edges and no-wrap at 1023
    pix(1, {10'd615, 10'd615}, 24'h0A0B0C, SP_FAR, 24'h112233,
        1, 4'd0, 24'h112233, 4'b0000);
    pix(1, {10'd616, 10'd600}, 24'h010203, SP_FAR, 24'h112233,
        1, 4'd1, 24'h010203, 4'b0000);
    pix(1, {10'd600, 10'd616}, 24'h040506, SP_FAR, 24'h112233,
        1, 4'd2, 24'h040506, 4'b0000);
    pix(1, {10'd1, 10'd1}, 24'h090909, {10'd1020, 10'd1020}, 24'h777777,
        1, 4'd3, 24'h090909, 4'b1010);
    pix(1, {10'd1023, 10'd1023}, 24'h090909, {10'd1020, 10'd1020},
        24'h777777, 1, 4'd4, 24'h777777, 4'b1010);
    @(posedge clk); #2;
    chk_bufs("wrap");

    // bank swap: B slots 0..2, A frozen
    pix(0, {10'd10, 10'd10}, 24'h414243, SP_FAR, 24'hAABBCC,
        0, 4'd0, 24'h414243, 4'b0000);
    pix(0, {10'd605, 10'd605}, 24'h515253, SP_FAR, 24'hAABBCC,
        0, 4'd1, 24'hAABBCC, 4'b0000);
    pix(0, {10'd11, 10'd10}, 24'h616263, SP_FAR, 24'hAABBCC,
        0, 4'd2, 24'h616263, 4'b0000);
    @(posedge clk); #2;
    chk_bufs("swap");

    // asynchronous reset mid-fill
    #1 reset = 1'b0;
    #1 model_clear();
    chk_bufs("async");
    chk("async collision", {124'd0, bus.collision}, 128'd0);
    @(posedge clk); #3 reset = 1'b1;
    pix(0, {10'd10, 10'd10}, 24'hC1C2C3, SP_FAR, 24'hAABBCC,
        0, 4'd0, 24'hC1C2C3, 4'b0000);
    pix(0, {10'd10, 10'd10}, 24'hD1D2D3, SP_FAR, 24'hAABBCC,
        0, 4'd1, 24'hD1D2D3, 4'b0000);
    @(posedge clk); #2;
    chk_bufs("restart");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_merge.md
Name: sprite_merge

Overview:
- Per-pixel compositor between the background and sprite pipelines and the VGA output stage.
- Each clock it merges one background pixel with the sprite colour, choosing the sprite when the background pixel lies inside the sprite box.
- The merged pixel is packed into one of two 16-pixel ping-pong line buffers (A/B); the VGA side reads the other buffer.
- Also flags the sprite touching the screen boundaries.

Parameters:
- SPRITE_W, 16, sprite box width in pixels.
- SPRITE_H, 16, sprite box height in pixels.
- X_MIN, 1, left boundary column.
- X_MAX, 990, right boundary column.
- Y_MIN, 1, top boundary row.
- Y_MAX, 990, bottom boundary row.
- TRANSP_KEY, 24'hFF00FF, sprite transparent colour {R,G,B}; used only with TRANSPARENCY_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- readVgaSelector  in  1  1: VGA reads B, merge writes A; 0: VGA reads A, merge writes B.
- R_bg, G_bg, B_bg  in  8 each  background pixel colour.
- posX_bg, posY_bg  in  10 each  screen coordinate of the background pixel.
- R_sp, G_sp, B_sp  in  8 each  sprite colour.
- posX_sp, posY_sp  in  10 each  sprite top-left coordinate.
- R_outRegA, G_outRegA, B_outRegA  out  128 each  buffer A, 16 pixels.
- R_outRegB, G_outRegB, B_outRegB  out  128 each  buffer B, 16 pixels.
- collision  out  4  boundary flags {bottom, top, right, left}.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk and reset).
- Reset (reset=0, asynchronous):
  - All six buffer registers = 0, collision = 0.
  - Write index = 0; registered previous selector = 1.
- Cover test: inside = (posX_sp <= posX_bg < posX_sp+SPRITE_W) and (posY_sp <= posY_bg < posY_sp+SPRITE_H).
  - Additions are 11-bit unsigned, so there is no wrap at 1023.
- Merged pixel: sprite RGB if inside, otherwise background RGB.
- Each rising edge out of reset:
  - The merged pixel is written to slot idx of the write bank (A if readVgaSelector=1, else B).
  - Slot i occupies bits [8i+7:8i] of each channel register; slot 0 is the LSBs.
  - The value is visible on the outputs immediately after that edge; latency is 1 cycle.
- Write index: 4-bit, increments every cycle, wraps 15->0. There is no full flag; the oldest slot is overwritten.
- Bank swap:
  - When readVgaSelector differs from its registered previous value, that cycle's pixel goes to slot 0 of the new write bank and idx becomes 1.
  - The bank now being read is never modified while it is the read bank.
- collision (registered, updated every cycle from the current posX_sp/posY_sp):
  - bit0 = posX_sp <= X_MIN
  - bit1 = posX_sp >= X_MAX
  - bit2 = posY_sp <= Y_MIN
  - bit3 = posY_sp >= Y_MAX
- Reset asserted mid-fill: both buffers clear immediately; filling restarts at slot 0.

Optional Feature:
- Macro: TRANSPARENCY_EN.
- Defined: a sprite pixel equal to TRANSP_KEY counts as not-inside, so the background pixel is passed.
- Undefined: the sprite is always opaque inside its box; TRANSP_KEY is ignored.

Test Plan:
- Reset then readVgaSelector=1, bg (500,500) RGB 20/50/40, sprite (1,1) RGB 17/17/17 -> R_outRegA[7:0]=0x20, G=0x50, B=0x40; buffer B stays 0; collision=4'b0101.
- Sprite (990,1) for one cycle -> collision=4'b0110; sprite (1,990) -> collision=4'b1001.
- bg (5,5) with sprite (1,1) RGB 17/17/17 -> slot holds 0x17 on all channels.
- 16 consecutive pixels into A -> slots 0..15 filled; the 17th pixel overwrites slot 0.
- Switch readVgaSelector to 0 and feed 3 pixels -> B slots 0..2 written; A unchanged.
- Assert reset mid-fill -> all outputs 0 asynchronously; after release, writes restart at slot 0.
